// File: rtl/spi_slave_param.sv
// Parametrised SPI slave frame engine: 2-bit command + DATA_W payload in, optional DATA_W read-back out.
// Define SPI_FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module spi_slave_param #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              SCLK,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              busy,
  output logic              frame_err
`ifdef SPI_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int RX_W  = DATA_W + 2;
  localparam int CNT_W = $clog2(RX_W + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, RX, WAIT_TX, SEND, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-2:0]   shreg_q, shreg_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
`ifdef SPI_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    tx_sh_d     = tx_sh_q;
    rx_valid_d  = 1'b0;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!SS_n) begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
      end
      CHK_CMD: begin
        shreg_d = {{(RX_W-2){1'b0}}, MOSI};
        cnt_d   = CNT_W'(1);
        state_d = RX;
      end
      RX: begin
        shreg_d = {shreg_q[RX_W-3:0], MOSI};
        cnt_d   = cnt_q + 1'b1;
        // shreg_q already holds every bit but the last one, command at its top
        if (cnt_q == CNT_W'(RX_W - 1)) begin
          rx_data_d  = {shreg_q, MOSI};
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = (shreg_q[RX_W-2 -: 2] == 2'b11) ? WAIT_TX : DONE;
        end
      end
      WAIT_TX: begin
        if (tx_valid) begin
          miso_d  = first_bit(tx_data);
          tx_sh_d = shift_out(tx_data);
          cnt_d   = CNT_W'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          miso_d  = first_bit(tx_sh_q);
          tx_sh_d = shift_out(tx_sh_q);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Deselect mid-frame beats everything, including the edge carrying the last RX bit
    if (SS_n && (state_q inside {CHK_CMD, RX, WAIT_TX, SEND})) begin
      state_d     = IDLE;
      cnt_d       = '0;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      miso_d      = 1'b0;
      frame_err_d = 1'b1;
    end

    tx_ready_d = (state_d == WAIT_TX);
    busy_d     = (state_d != IDLE);
`ifdef SPI_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q + 16'(rx_valid_d);
`endif
  end

  always_ff @(posedge SCLK) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      tx_sh_q     <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      tx_sh_q     <= tx_sh_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign MISO      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SPI_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: one MSB-first and one LSB-first instance driven in parallel.
module tb_spi_slave_param;

  localparam int DATA_W = 8;
  localparam int RX_W   = DATA_W + 2;

  typedef enum {EV_RX, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e        kind;
    logic [RX_W-1:0] word;
  } ev_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    int                n;
  } tx_exp_t;

  logic              SCLK = 1'b0;
  logic              rst, SS_n, MOSI, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready_o [2];
  logic              rx_valid_o [2];
  logic              miso_o [2];
  logic              busy_o [2];
  logic              frame_err_o [2];
  logic [RX_W-1:0]   rx_data_o [2];
`ifdef SPI_FRAME_CNT_EN
  logic [15:0]       frame_cnt_o [2];
`endif

  ev_t             ev_q[$];
  tx_exp_t         tx_q[$];
  int              total = 0;
  int              bad   = 0;
  logic [RX_W-1:0] last_rx;
  logic [15:0]     exp_frames;

  always #5 SCLK = ~SCLK;

  spi_slave_param #(.DATA_W(DATA_W), .MSB_FIRST(1'b1)) u_msb (
    .SCLK(SCLK), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_o[0]),
    .rx_data(rx_data_o[0]), .rx_valid(rx_valid_o[0]), .MISO(miso_o[0]),
    .busy(busy_o[0]), .frame_err(frame_err_o[0])
`ifdef SPI_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_o[0])
`endif
  );

  spi_slave_param #(.DATA_W(DATA_W), .MSB_FIRST(1'b0)) u_lsb (
    .SCLK(SCLK), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_o[1]),
    .rx_data(rx_data_o[1]), .rx_valid(rx_valid_o[1]), .MISO(miso_o[1]),
    .busy(busy_o[1]), .frame_err(frame_err_o[1])
`ifdef SPI_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_o[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position of bit i of the serial stream within the word, from the bit order alone
  function automatic logic model_bit(input logic [DATA_W-1:0] d, input int i, input bit msb_first);
    int pos;
    pos = msb_first ? (DATA_W - 1 - i) : i;
    return ((d >> pos) & 1) != 0;
  endfunction

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rx_data[%0d]", d), rx_data_o[d], 0);
      check($sformatf("rst_rx_valid[%0d]", d), rx_valid_o[d], 0);
      check($sformatf("rst_miso[%0d]", d), miso_o[d], 0);
      check($sformatf("rst_tx_ready[%0d]", d), tx_ready_o[d], 0);
      check($sformatf("rst_busy[%0d]", d), busy_o[d], 0);
      check($sformatf("rst_frame_err[%0d]", d), frame_err_o[d], 0);
`ifdef SPI_FRAME_CNT_EN
      check($sformatf("rst_frame_cnt[%0d]", d), frame_cnt_o[d], 0);
`endif
    end
    last_rx    = '0;
    exp_frames = '0;
  endtask

  task automatic check_abort();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_busy[%0d]", d), busy_o[d], 0);
      check($sformatf("abort_miso[%0d]", d), miso_o[d], 0);
      check($sformatf("abort_tx_ready[%0d]", d), tx_ready_o[d], 0);
      check($sformatf("abort_rx_data_kept[%0d]", d), rx_data_o[d], last_rx);
    end
  endtask

  // abort_bit: SS_n high on the edge that would sample that frame bit (-1 = none)
  // abort_send / rst_send: deselect / reset after that many MISO bits (0 = none)
  task automatic run_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] pay,
                           input logic [DATA_W-1:0] txd, input int tx_delay,
                           input int abort_bit, input bit abort_wait,
                           input int abort_send, input int rst_send);
    logic [RX_W-1:0] word;
    tx_exp_t         t;
    word     = {cmd, pay};
    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = 1'b0;
    tick();
    check("start_busy", busy_o[0] & busy_o[1], 1);
    for (int b = 0; b < RX_W; b++) begin
      MOSI     = word[RX_W-1-b];
      tx_valid = 1'($urandom);
      tx_data  = DATA_W'($urandom);
      if (b == abort_bit) begin
        SS_n = 1'b1;
        ev_q.push_back('{EV_ERR, '0});
        tick();
        check_abort();
        tx_valid = 1'b0;
        return;
      end
      if (b == RX_W - 1) ev_q.push_back('{EV_RX, word});
      tick();
      check("rx_miso_idle", miso_o[0] | miso_o[1], 0);
    end
    tx_valid   = 1'b0;
    last_rx    = word;
    exp_frames = exp_frames + 16'd1;
    check("post_rx_tx_ready_m", tx_ready_o[0], cmd == 2'b11);
    check("post_rx_tx_ready_l", tx_ready_o[1], cmd == 2'b11);
    if (cmd == 2'b11) begin
      if (abort_wait) begin
        SS_n = 1'b1;
        ev_q.push_back('{EV_ERR, '0});
        tick();
        check_abort();
        return;
      end
      for (int i = 0; i < tx_delay; i++) begin
        tick();
        check("wait_tx_ready", tx_ready_o[0] & tx_ready_o[1], 1);
      end
      tx_valid = 1'b1;
      tx_data  = txd;
      t.data   = txd;
      t.n      = (abort_send > 0) ? abort_send : ((rst_send > 0) ? rst_send : DATA_W);
      tx_q.push_back(t);
      tick();
      tx_valid = 1'b0;
      tx_data  = DATA_W'($urandom);
      check("send_tx_ready_low", tx_ready_o[0] | tx_ready_o[1], 0);
      if (abort_send > 0) begin
        repeat (abort_send - 1) tick();
        SS_n = 1'b1;
        ev_q.push_back('{EV_ERR, '0});
        tick();
        check_abort();
        return;
      end
      if (rst_send > 0) begin
        repeat (rst_send - 1) tick();
        rst  = 1'b1;
        SS_n = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        return;
      end
      repeat (DATA_W) tick();
    end
    check("done_busy", busy_o[0] & busy_o[1], 1);
    check("done_miso", miso_o[0] | miso_o[1], 0);
    repeat ($urandom_range(0, 2)) begin
      MOSI = 1'($urandom);
      tick();
    end
    SS_n = 1'b1;
    tick();
    check("end_busy", busy_o[0] | busy_o[1], 0);
  endtask

  // Monitor: rx_valid / frame_err strobes against the ordered event queue
  always @(negedge SCLK) begin
    ev_t e;
    if (rx_valid_o[0] | rx_valid_o[1] | frame_err_o[0] | frame_err_o[1]) begin
      if (ev_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: rx_valid=%b/%b frame_err=%b/%b, expected none",
                 rx_valid_o[0], rx_valid_o[1], frame_err_o[0], frame_err_o[1]);
      end else begin
        e = ev_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          check($sformatf("rx_valid[%0d]", d), rx_valid_o[d], e.kind == EV_RX);
          check($sformatf("frame_err[%0d]", d), frame_err_o[d], e.kind == EV_ERR);
          if (e.kind == EV_RX) check($sformatf("rx_data[%0d]", d), rx_data_o[d], e.word);
        end
      end
    end
  end

  // Monitor: serial read-back following each tx handshake
  initial begin
    tx_exp_t t;
    forever begin
      @(negedge SCLK);
      if (tx_ready_o[0] && tx_valid && !rst) begin
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_handshake: tx_data=%0h, expected none", tx_data);
        end else begin
          t = tx_q.pop_front();
          for (int i = 0; i < t.n; i++) begin
            @(negedge SCLK);
            check($sformatf("miso_msb_bit%0d", i), miso_o[0], model_bit(t.data, i, 1'b1));
            check($sformatf("miso_lsb_bit%0d", i), miso_o[1], model_bit(t.data, i, 1'b0));
          end
          @(negedge SCLK);
          check("miso_after_send", miso_o[0] | miso_o[1], 0);
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] cmd;
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick();
    tick();
    check_reset();
    rst = 1'b0;

    run_frame(2'b00, 8'hA5, 8'h00, 0, -1, 1'b0, 0, 0);
    run_frame(2'b10, 8'h3C, 8'h00, 0, -1, 1'b0, 0, 0);
    run_frame(2'b11, 8'h00, 8'hC3, 3, -1, 1'b0, 0, 0);
    run_frame(2'b11, 8'h7E, 8'h01, 0, -1, 1'b0, 0, 0);
    run_frame(2'b01, 8'h5A, 8'h00, 0, 7, 1'b0, 0, 0);
    run_frame(2'b00, 8'hFF, 8'h00, 0, 0, 1'b0, 0, 0);
    run_frame(2'b11, 8'h81, 8'h00, 0, RX_W - 1, 1'b0, 0, 0);
    run_frame(2'b11, 8'h42, 8'hAA, 0, -1, 1'b1, 0, 0);
    run_frame(2'b11, 8'h24, 8'h96, 2, -1, 1'b0, 3, 0);
    run_frame(2'b11, 8'h18, 8'h6D, 1, -1, 1'b0, DATA_W, 0);

    for (int k = 0; k < 40; k++) begin
      r   = int'($urandom_range(0, 9));
      cmd = 2'($urandom);
      run_frame(cmd, DATA_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, 4)),
                (r == 0) ? int'($urandom_range(0, RX_W - 1)) : -1,
                r == 1,
                (r == 2) ? int'($urandom_range(1, DATA_W)) : 0, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
`ifdef SPI_FRAME_CNT_EN
    check("frame_cnt_random_m", frame_cnt_o[0], exp_frames);
    check("frame_cnt_random_l", frame_cnt_o[1], exp_frames);
`endif

    run_frame(2'b11, 8'h33, 8'h5C, 1, -1, 1'b0, 0, 4);

    run_frame(2'b00, 8'h11, 8'h00, 0, -1, 1'b0, 0, 0);
    run_frame(2'b11, 8'h22, 8'hE7, 2, -1, 1'b0, 0, 0);
    run_frame(2'b10, 8'h44, 8'h00, 0, 4, 1'b0, 0, 0);
    run_frame(2'b01, 8'h88, 8'h00, 0, -1, 1'b0, 0, 0);
`ifdef SPI_FRAME_CNT_EN
    check("frame_cnt_three_m", frame_cnt_o[0], 3);
    check("frame_cnt_three_l", frame_cnt_o[1], 3);
`endif

    repeat (4) tick();
    check("events_drained", ev_q.size(), 0);
    check("tx_drained", tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
